// File: rtl/adc_pkg.sv
// Shared definitions for the serial angle ADC responder and its controller.
`timescale 1ns/1ps
package adc_pkg;

    localparam int unsigned ADC_DATA_W      = 12;
    localparam int unsigned ADC_LEAD_BITS   = 3;
    localparam int unsigned ADC_SYNC_STAGES = 2;

    // Idle (deselected) pin levels of the controller-driven lines
    localparam logic CLK_ADC_IDLE = 1'b1;
    localparam logic CS_N_IDLE    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQ,
        ST_NULLB,
        ST_DATA,
        ST_HOLD
    } adc_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// N-stage synchronizer with rise/fall pulses on the last stage.
`timescale 1ns/1ps
module sync_edge_det #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;
    logic [STAGES:0]   primed_q;

    // Synchronizer chain, edge delay copy and post-reset settle tracker.
    // Edges are suppressed until the chain has filled with real pin samples,
    // so a line already at its active level after reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {STAGES{RST_VAL}};
            dly_q    <= RST_VAL;
            primed_q <= '0;
        end else begin
            sync_q   <= {sync_q[STAGES-2:0], din};
            dly_q    <= sync_q[STAGES-1];
            primed_q <= {primed_q[STAGES-1:0], 1'b1};
        end
    end

    assign rise_c = primed_q[STAGES] &  sync_q[STAGES-1] & ~dly_q;
    assign fall_c = primed_q[STAGES] & ~sync_q[STAGES-1] &  dly_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Responder end of the serial angle ADC link: shifts a latched sample out MSB first.
`timescale 1ns/1ps
module adc_serial_responder
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W      = ADC_DATA_W,
    parameter int unsigned LEAD_BITS   = ADC_LEAD_BITS,
    parameter int unsigned SYNC_STAGES = ADC_SYNC_STAGES
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              clk_adc,
    input  logic              cs_n,
    input  logic [DATA_W-1:0] sample_value,
    output logic              angle_barre,
    output logic              dout_oe,
    output logic [DATA_W-1:0] sample_latched,
    output logic              frame_done,
    output logic              frame_abort
);

    localparam int unsigned CNT_W = $clog2(DATA_W + LEAD_BITS);
    localparam logic [CNT_W-1:0] ACQ_LAST  = CNT_W'(LEAD_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic adc_fall;
    logic adc_rise_unused;
    logic cs_fall;
    logic cs_rise;

    adc_state_t        state_q,  state_nxt;
    logic [CNT_W-1:0]  cnt_q,    cnt_nxt;
    logic [DATA_W-1:0] shift_q,  shift_nxt;
    logic [DATA_W-1:0] latched_nxt;
    logic              angle_nxt;
    logic              oe_nxt;
    logic              done_nxt;
    logic              abort_nxt;

    sync_edge_det #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (CLK_ADC_IDLE)
    ) u_clk_adc_sync (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .din    (clk_adc),
        .rise_c (adc_rise_unused),
        .fall_c (adc_fall)
    );

    sync_edge_det #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (CS_N_IDLE)
    ) u_cs_n_sync (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .din    (cs_n),
        .rise_c (cs_rise),
        .fall_c (cs_fall)
    );

    // State, counter, shift register and registered outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            sample_latched <= '0;
            angle_barre    <= 1'b0;
            dout_oe        <= 1'b0;
            frame_done     <= 1'b0;
            frame_abort    <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            cnt_q          <= cnt_nxt;
            shift_q        <= shift_nxt;
            sample_latched <= latched_nxt;
            angle_barre    <= angle_nxt;
            dout_oe        <= oe_nxt;
            frame_done     <= done_nxt;
            frame_abort    <= abort_nxt;
        end
    end

    // Frame sequencing: lead-in falls, MSB-first data, LSB hold, abort on early deselect.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        shift_nxt   = shift_q;
        latched_nxt = sample_latched;
        angle_nxt   = angle_barre;
        oe_nxt      = dout_oe;
        done_nxt    = 1'b0;
        abort_nxt   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                oe_nxt    = 1'b0;
                angle_nxt = 1'b0;
                // cs_n fall wins; a coincident clk_adc fall is simply not counted
                if (cs_fall) begin
                    latched_nxt = sample_value;
                    shift_nxt   = sample_value;
                    cnt_nxt     = '0;
                    oe_nxt      = 1'b1;
                    state_nxt   = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (adc_fall) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                    if (cnt_q == ACQ_LAST) begin
                        angle_nxt = 1'b0;
                        state_nxt = ST_NULLB;
                    end
                end
            end
            ST_NULLB: begin
                if (adc_fall) begin
                    angle_nxt = shift_q[DATA_W-1];
                    shift_nxt = shift_q << 1;
                    cnt_nxt   = '0;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (adc_fall) begin
                    if (cnt_q == DATA_LAST) begin
                        angle_nxt = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_HOLD;
                    end else begin
                        angle_nxt = shift_q[DATA_W-1];
                        shift_nxt = shift_q << 1;
                        cnt_nxt   = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                angle_nxt = 1'b0;
                if (cs_rise) begin
                    oe_nxt    = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                oe_nxt    = 1'b0;
                angle_nxt = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase

        // Deselect before the frame completed
        if (cs_rise && (state_q == ST_ACQ || state_q == ST_NULLB || state_q == ST_DATA)) begin
            shift_nxt = shift_q;
            cnt_nxt   = cnt_q;
            angle_nxt = 1'b0;
            oe_nxt    = 1'b0;
            done_nxt  = 1'b0;
            abort_nxt = 1'b1;
            state_nxt = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder acting as the ADC controller.
`timescale 1ns/1ps
module tb_adc_serial_responder;

    localparam int unsigned W = 12;

    logic         clk          = 1'b0;
    logic         rst_n        = 1'b0;
    logic         clk_adc      = 1'b1;
    logic         cs_n         = 1'b1;
    logic [W-1:0] sample_value = '0;
    logic         angle_barre;
    logic         dout_oe;
    logic [W-1:0] sample_latched;
    logic         frame_done;
    logic         frame_abort;

    int  nvec      = 0;
    int  nerr      = 0;
    int  done_cnt  = 0;
    int  abort_cnt = 0;
    int  d0;
    int  a0;
    time last_chg  = 0;

    logic rs  [1:32];
    logic ors [1:32];

    adc_serial_responder dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .clk_adc        (clk_adc),
        .cs_n           (cs_n),
        .sample_value   (sample_value),
        .angle_barre    (angle_barre),
        .dout_oe        (dout_oe),
        .sample_latched (sample_latched),
        .frame_done     (frame_done),
        .frame_abort    (frame_abort)
    );

    // 50 MHz system clock
    always #10 clk = ~clk;

    // Count cycles each pulse output is high
    always @(negedge clk) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    // Time of the latest serial data transition
    always @(angle_barre) last_chg = $time;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clk_adc period: fall, then rise where the controller samples
    task automatic adc_tick(input int half, input int k, input bit setup_chk);
        clk_adc = 1'b0;
        cyc(half);
        clk_adc = 1'b1;
        rs[k]  = angle_barre;
        ors[k] = dout_oe;
        if (setup_chk)
            chk($sformatf("setup_rise%0d", k), 32'(($time - last_chg) >= 20), 32'd1);
        cyc(half);
    endtask

    task automatic frame(input logic [W-1:0] v, input int half, input int nclk, input bit setup_chk);
        for (int i = 1; i <= 32; i++) begin
            rs[i]  = 1'bx;
            ors[i] = 1'bx;
        end
        sample_value = v;
        cs_n = 1'b0;
        cyc(2 * half);
        for (int k = 1; k <= nclk; k++) adc_tick(half, k, setup_chk);
    endtask

    task automatic frame_close(input int half);
        cs_n = 1'b1;
        cyc(2 * half + 6);
    endtask

    function automatic logic [W-1:0] word_at(input int first);
        logic [W-1:0] w;
        for (int i = 0; i < int'(W); i++) w[W-1-i] = rs[first+i];
        return w;
    endfunction

    function automatic logic any_rs(input int a, input int b);
        logic r = 1'b0;
        for (int i = a; i <= b; i++) r = r | rs[i];
        return r;
    endfunction

    function automatic logic all_oe(input int a, input int b);
        logic r = 1'b1;
        for (int i = a; i <= b; i++) r = r & ors[i];
        return r;
    endfunction

    function automatic logic any_oe(input int a, input int b);
        logic r = 1'b0;
        for (int i = a; i <= b; i++) r = r | ors[i];
        return r;
    endfunction

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(5);

        // Reset state
        chk("rst_angle",   32'(angle_barre),    32'd0);
        chk("rst_oe",      32'(dout_oe),        32'd0);
        chk("rst_latched", 32'(sample_latched), 32'd0);
        chk("rst_done",    32'(frame_done),     32'd0);
        chk("rst_abort",   32'(frame_abort),    32'd0);

        // Nominal 1 MHz frame
        d0 = done_cnt; a0 = abort_cnt;
        frame(12'hA5C, 25, 16, 1'b0);
        chk("nom_lead",    32'({rs[1], rs[2], rs[3]}), 32'd0);
        chk("nom_data",    32'(word_at(4)),        32'hA5C);
        chk("nom_oe",      32'(all_oe(1, 16)),     32'd1);
        chk("nom_tail",    32'(rs[16]),            32'd0);
        chk("nom_latched", 32'(sample_latched),    32'hA5C);
        chk("nom_done",    32'(done_cnt - d0),     32'd1);
        frame_close(25);
        chk("nom_oe_off",  32'(dout_oe),           32'd0);
        chk("nom_abort",   32'(abort_cnt - a0),    32'd0);

        // All ones: null/acquisition bits still zero
        frame(12'hFFF, 25, 16, 1'b0);
        chk("ff_lead",     32'({rs[1], rs[2], rs[3]}), 32'd0);
        chk("ff_lead_oe",  32'(all_oe(1, 3)),      32'd1);
        chk("ff_data",     32'(word_at(4)),        32'hFFF);
        frame_close(25);

        // All zeros
        d0 = done_cnt;
        frame(12'h000, 25, 16, 1'b0);
        chk("zero_data",   32'(word_at(4)),        32'h000);
        chk("zero_done",   32'(done_cnt - d0),     32'd1);
        frame_close(25);

        // Abort after fall 8
        d0 = done_cnt; a0 = abort_cnt;
        frame(12'h3C5, 25, 8, 1'b0);
        cs_n = 1'b1;
        cyc(4);
        chk("abt_oe_off",  32'(dout_oe),           32'd0);
        chk("abt_angle",   32'(angle_barre),       32'd0);
        cyc(10);
        chk("abt_pulse",   32'(abort_cnt - a0),    32'd1);
        chk("abt_no_done", 32'(done_cnt - d0),     32'd0);
        chk("abt_latched", 32'(sample_latched),    32'h3C5);
        frame(12'h3C5, 25, 16, 1'b0);
        chk("abt_next",    32'(word_at(4)),        32'h3C5);
        frame_close(25);

        // Overclocked frame: extra clocks in hold emit nothing
        d0 = done_cnt;
        frame(12'h801, 25, 20, 1'b0);
        chk("oc_data",     32'(word_at(4)),        32'h801);
        chk("oc_tail",     32'(any_rs(16, 20)),    32'd0);
        chk("oc_oe",       32'(ors[20]),           32'd1);
        chk("oc_done",     32'(done_cnt - d0),     32'd1);
        frame_close(25);

        // Sample change at fall 6, then async reset after fall 10
        d0 = done_cnt;
        sample_value = 12'h123;
        cs_n = 1'b0;
        cyc(50);
        for (int k = 1; k <= 9; k++) begin
            if (k == 6) sample_value = 12'h456;
            adc_tick(25, k, 1'b0);
        end
        chk("mid_partial", 32'({rs[4], rs[5], rs[6], rs[7], rs[8], rs[9]}), 32'h04);
        clk_adc = 1'b0;
        cyc(25);
        chk("mid_latched", 32'(sample_latched),    32'h123);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_angle",   32'(angle_barre),    32'd0);
        chk("mid_rst_oe",      32'(dout_oe),        32'd0);
        chk("mid_rst_latched", 32'(sample_latched), 32'd0);
        chk("mid_rst_done",    32'(frame_done),     32'd0);
        chk("mid_rst_abort",   32'(frame_abort),    32'd0);
        #2;
        rst_n = 1'b1;
        cyc(2);
        clk_adc = 1'b1;
        cyc(25);
        for (int k = 11; k <= 16; k++) adc_tick(25, k, 1'b0);
        chk("mid_no_resume",   32'(any_oe(11, 16)), 32'd0);
        chk("mid_no_done",     32'(done_cnt - d0),  32'd0);
        frame_close(25);
        frame(12'h456, 25, 16, 1'b0);
        chk("mid_next",        32'(word_at(4)),     32'h456);
        frame_close(25);

        // Ratio limit: clk_adc at clk_clk/4; data appears one rise later
        d0 = done_cnt;
        frame(12'h5A5, 2, 16, 1'b1);
        chk("ratio_data",      32'(word_at(5)),     32'h5A5);
        cyc(6);
        chk("ratio_done",      32'(done_cnt - d0),  32'd1);
        frame_close(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
